ex_mdu_ctrl: RTL and testbench
==============================

EX_MDU_CTRL -- requirements
Module: ex_mdu_ctrl

Multi-cycle multiply/divide sequencer for the EX stage: owns HI/LO, runs MULT/DIV with fixed latency, and raises a stall request toward the hazard unit.

Interface
REQ-001 SHALL have parameter MULT_CYCLES, default 5, busy cycles for MULT/MULTU (range 1..31).
REQ-002 SHALL have parameter DIV_CYCLES, default 10, busy cycles for DIV/DIVU (range 1..31).
REQ-003 SHALL have port clk  input  1  sole clock; all state updates on the rising edge.
REQ-004 SHALL have port reset  input  1  asynchronous, active-low reset (0 = in reset).
REQ-005 SHALL have port start  input  1  EX-stage instruction is a valid MDU op this cycle.
REQ-006 SHALL have port mdu_op  input  3  0 MULT, 1 MULTU, 2 DIV, 3 DIVU, 4 MTHI, 5 MTLO, 6 MFHI, 7 MFLO.
REQ-007 SHALL have port a  input  32  rs operand (dividend / multiplicand / MTxx source).
REQ-008 SHALL have port b  input  32  rt operand (divisor / multiplier).
REQ-009 SHALL have port id_is_md  input  1  ID-stage instruction is any MDU op (0-7).
REQ-010 SHALL have port busy  output  1  computation in progress.
REQ-011 SHALL have port rd_data  output  32  HI if mdu_op==6, else LO; combinational.
REQ-012 SHALL have port stall_req  output  1  stall ID stage.

Function
REQ-013 The block SHALL have two states, IDLE and RUN, held with a 5-bit down-counter cnt.
REQ-014 In IDLE with start=1 and mdu_op in 0..3, the block SHALL latch a, b and op, load cnt with MULT_CYCLES or DIV_CYCLES, and enter RUN at that edge.
REQ-015 In RUN, busy SHALL be 1, and cnt SHALL decrement each edge.
REQ-016 On the edge where cnt==1 in RUN, the block SHALL write HI/LO and return to IDLE, so busy is high for exactly N consecutive cycles starting the cycle after start.
REQ-017 MULT SHALL form the signed 64-bit product and MULTU the unsigned one; HI takes product[63:32] and LO takes product[31:0].
REQ-018 DIV/DIVU SHALL set LO to the quotient truncated toward zero and HI to the remainder, where the remainder has the sign of the dividend.
REQ-019 For DIV, 0x80000000 / 0xFFFFFFFF SHALL give LO=0x80000000, HI=0.
REQ-020 For a divisor of 0 (DIV or DIVU), HI/LO SHALL be left unchanged at completion; timing is unchanged.
REQ-021 MTHI/MTLO with start=1 in IDLE SHALL write a into HI/LO on the next edge; busy stays 0.
REQ-022 start=1 while in RUN SHALL be ignored: no relatch, no HI/LO write, cnt unaffected.
REQ-023 MFHI/MFLO SHALL never change state; rd_data reflects HI/LO as registered, with no forwarding from an in-flight op.
REQ-024 stall_req SHALL equal id_is_md & (busy | (start & mdu_op<=3)), i.e. it also stalls in the start cycle.
REQ-025 Results SHALL be computed from the latched operands only; changes on a/b during RUN have no effect.

Reset
REQ-026 When reset=0, the block SHALL immediately force state=IDLE, cnt=0, busy=0, HI=0, LO=0, and therefore stall_req=0 and rd_data=0.
REQ-027 Reset asserted during RUN SHALL abort the operation with no HI/LO write; after release the block accepts a new start on the first edge.
REQ-028 Deassertion of reset SHALL take effect at the next rising edge of clk without glitching busy.

Verification
REQ-029 MULT a=0xFFFFFFFE (-2), b=3 -> busy high for 5 cycles, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; MULTU with the same operands -> HI=0x00000002, LO=0xFFFFFFFA.
REQ-030 DIV a=0xFFFFFFF9 (-7), b=2 -> busy high for 10 cycles, then LO=0xFFFFFFFD, HI=0xFFFFFFFF; DIVU a=7, b=0 with prior HI=0x11, LO=0x22 -> HI/LO unchanged after 10 busy cycles.
REQ-031 MULT started with id_is_md=1 held -> stall_req=1 in the start cycle and all 5 busy cycles, then 0; with id_is_md=0 -> stall_req=0 throughout.
REQ-032 Second start (DIV) issued on busy cycle 3 of a MULT -> ignored; HI/LO hold the MULT result and busy falls after 5 cycles total.
REQ-033 MTHI a=0xDEADBEEF, then MFHI -> rd_data=0xDEADBEEF one cycle later, busy=0 throughout.
REQ-034 reset pulled low on busy cycle 7 of a DIV -> busy=0 and HI=LO=0 immediately; a MULT 1x1 started after release -> LO=1 after 5 cycles.

Source files
------------

// File: rtl/ex_mdu_ctrl.sv
// EX-stage multiply/divide sequencer: owns HI/LO, runs MULT/DIV with a fixed
// latency and asks the hazard unit to stall ID while an MDU op is in flight.
module ex_mdu_ctrl #(
    parameter int MULT_CYCLES = 5,
    parameter int DIV_CYCLES  = 10
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        start,
    input  logic [2:0]  mdu_op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        id_is_md,
    output logic        busy,
    output logic [31:0] rd_data,
    output logic        stall_req
);

    typedef enum logic {
        IDLE,
        RUN
    } state_t;

    localparam logic [4:0] MULT_LOAD = 5'(MULT_CYCLES);
    localparam logic [4:0] DIV_LOAD  = 5'(DIV_CYCLES);

    state_t      state, state_nxt;
    logic [4:0]  cnt, cnt_nxt;
    logic [1:0]  op_q;
    logic [31:0] a_q, b_q;
    logic [31:0] hi, lo, hi_nxt, lo_nxt;
    logic        capture;

    // One multiplier serves both flavours: the extension bit selects signedness.
    logic        mul_ext_a, mul_ext_b;
    logic [63:0] prod;

    always_comb begin
        mul_ext_a = ~op_q[0] & a_q[31];
        mul_ext_b = ~op_q[0] & b_q[31];
        prod      = {{32{mul_ext_a}}, a_q} * {{32{mul_ext_b}}, b_q};
    end

    // Signed divide is done on magnitudes, which also makes 0x80000000 / -1
    // fall out naturally instead of overflowing a signed divider.
    logic        a_neg, b_neg;
    logic [31:0] a_mag, b_mag, b_div, q_mag, r_mag, quo, rem;

    always_comb begin
        a_neg = ~op_q[0] & a_q[31];
        b_neg = ~op_q[0] & b_q[31];
        a_mag = a_neg ? -a_q : a_q;
        b_mag = b_neg ? -b_q : b_q;
        b_div = (b_mag == 32'd0) ? 32'd1 : b_mag;
        q_mag = a_mag / b_div;
        r_mag = a_mag % b_div;
        quo   = (a_neg ^ b_neg) ? -q_mag : q_mag;
        rem   = a_neg ? -r_mag : r_mag;
    end

    // NOTE: every signal written here gets a default first so no latch is inferred.
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        hi_nxt    = hi;
        lo_nxt    = lo;
        capture   = 1'b0;
        case (state)
            IDLE: begin
                if (start) begin
                    case (mdu_op)
                        3'd0, 3'd1, 3'd2, 3'd3: begin
                            capture   = 1'b1;
                            state_nxt = RUN;
                            cnt_nxt   = mdu_op[1] ? DIV_LOAD : MULT_LOAD;
                        end
                        3'd4:    hi_nxt = a;
                        3'd5:    lo_nxt = a;
                        default: ;
                    endcase
                end
            end
            RUN: begin
                cnt_nxt = cnt - 5'd1;
                if (cnt <= 5'd1) begin
                    state_nxt = IDLE;
                    cnt_nxt   = 5'd0;
                    if (!op_q[1]) begin
                        hi_nxt = prod[63:32];
                        lo_nxt = prod[31:0];
                    end else if (b_q != 32'd0) begin
                        hi_nxt = rem;
                        lo_nxt = quo;
                    end
                end
            end
            default: begin
                state_nxt = IDLE;
                cnt_nxt   = 5'd0;
            end
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments only, so every flop
    // samples the pre-edge values regardless of block ordering.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state <= IDLE;
            cnt   <= 5'd0;
            hi    <= 32'd0;
            lo    <= 32'd0;
        end else begin
            state <= state_nxt;
            cnt   <= cnt_nxt;
            hi    <= hi_nxt;
            lo    <= lo_nxt;
        end
    end

    // NOTE: operand latches are never observed outside RUN, so they need no reset.
    always_ff @(posedge clk) begin
        if (capture) begin
            op_q <= mdu_op[1:0];
            a_q  <= a;
            b_q  <= b;
        end
    end

    assign busy      = (state == RUN);
    assign rd_data   = (mdu_op == 3'd6) ? hi : lo;
    assign stall_req = id_is_md & (busy | (start & ~mdu_op[2]));

endmodule

// File: tb/tb_ex_mdu_ctrl.sv
// Self-checking bench for ex_mdu_ctrl: a behavioural HI/LO model compared on
// every cycle, plus directed vectors with hand-computed literal results.
module tb_ex_mdu_ctrl;

    localparam int MULT_N = 5;
    localparam int DIV_N  = 10;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        start = 1'b0;
    logic [2:0]  mdu_op = 3'd7;
    logic [31:0] a = 32'd0;
    logic [31:0] b = 32'd0;
    logic        id_is_md = 1'b0;
    logic        busy;
    logic [31:0] rd_data;
    logic        stall_req;

    int n_cmp = 0;
    int n_err = 0;

    ex_mdu_ctrl #(.MULT_CYCLES(MULT_N), .DIV_CYCLES(DIV_N)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .mdu_op    (mdu_op),
        .a         (a),
        .b         (b),
        .id_is_md  (id_is_md),
        .busy      (busy),
        .rd_data   (rd_data),
        .stall_req (stall_req)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: an op's result is worked out from its operands at
    // issue time and simply becomes visible after the fixed latency.
    logic [31:0] m_hi, m_lo, p_hi, p_lo;
    logic        p_write;
    int          m_left;

    always @(posedge clk or negedge reset) begin
        if (!reset) begin
            m_hi = 0; m_lo = 0; m_left = 0; p_write = 0;
        end else if (m_left > 0) begin
            m_left--;
            if (m_left == 0 && p_write) begin
                m_hi = p_hi; m_lo = p_lo;
            end
        end else if (start) begin
            longint sa, sb, prod, q, r;
            sa = longint'($signed(a));
            sb = longint'($signed(b));
            p_write = 1;
            case (mdu_op)
                3'd0: begin prod = sa * sb; {p_hi, p_lo} = prod; m_left = MULT_N; end
                3'd1: begin prod = longint'({32'd0, a}) * longint'({32'd0, b});
                            {p_hi, p_lo} = prod; m_left = MULT_N; end
                3'd2: begin
                    m_left = DIV_N;
                    if (b == 0) p_write = 0;
                    else begin q = sa / sb; r = sa % sb; p_lo = q[31:0]; p_hi = r[31:0]; end
                end
                3'd3: begin
                    m_left = DIV_N;
                    if (b == 0) p_write = 0;
                    else begin p_lo = a / b; p_hi = a % b; end
                end
                3'd4: m_hi = a;
                3'd5: m_lo = a;
                default: ;
            endcase
        end
    end

    always @(negedge clk) begin
        logic m_busy;
        m_busy = (m_left > 0);
        check("cyc_busy", {31'd0, busy}, {31'd0, m_busy});
        check("cyc_stall", {31'd0, stall_req},
              {31'd0, id_is_md & (m_busy | (start & (mdu_op <= 3'd3)))});
        check("cyc_rd_data", rd_data, (mdu_op == 3'd6) ? m_hi : m_lo);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [2:0] op, input logic [31:0] av, input logic [31:0] bv,
                         input logic md);
        start = 1'b1; mdu_op = op; a = av; b = bv; id_is_md = md;
        step();
        start = 1'b0; mdu_op = 3'd7;
    endtask

    task automatic wait_idle(output int n);
        n = 0;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (busy) n++;
            else return;
        end
        check("busy_timeout", 32'd1, 32'd0);
    endtask

    task automatic read_hilo(input string name, input logic [31:0] ehi, input logic [31:0] elo);
        step();
        mdu_op = 3'd6; #1;
        check({name, "_hi"}, rd_data, ehi);
        mdu_op = 3'd7; #1;
        check({name, "_lo"}, rd_data, elo);
    endtask

    initial begin
        int n;
        #2;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_rd", rd_data, 32'd0);
        check("rst_stall", {31'd0, stall_req}, 32'd0);
        step();
        reset = 1'b1;
        step();

        // MULT -2 * 3 with ID stalled behind it
        start = 1'b1; mdu_op = 3'd0; a = 32'hFFFF_FFFE; b = 32'd3; id_is_md = 1'b1; #1;
        check("start_cycle_stall", {31'd0, stall_req}, 32'd1);
        step();
        start = 1'b0; mdu_op = 3'd7;
        wait_idle(n);
        check("mult_busy_cycles", n, 32'd5);
        check("stall_released", {31'd0, stall_req}, 32'd0);
        read_hilo("mult", 32'hFFFF_FFFF, 32'hFFFF_FFFA);

        issue(3'd1, 32'hFFFF_FFFE, 32'd3, 1'b0);
        wait_idle(n);
        read_hilo("multu", 32'h0000_0002, 32'hFFFF_FFFA);

        issue(3'd2, 32'hFFFF_FFF9, 32'd2, 1'b1);
        wait_idle(n);
        check("div_busy_cycles", n, 32'd10);
        read_hilo("div_neg", 32'hFFFF_FFFF, 32'hFFFF_FFFD);

        // DIVU by zero keeps HI/LO
        step();
        issue(3'd4, 32'h11, 32'd0, 1'b0);
        issue(3'd5, 32'h22, 32'd0, 1'b0);
        issue(3'd3, 32'd7, 32'd0, 1'b1);
        wait_idle(n);
        check("divu0_busy_cycles", n, 32'd10);
        read_hilo("divu0", 32'h11, 32'h22);

        step();
        issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF, 1'b0);
        wait_idle(n);
        read_hilo("div_ovf", 32'h0, 32'h8000_0000);

        step();
        issue(3'd2, 32'd100, 32'd7, 1'b0);
        wait_idle(n);
        read_hilo("div_pos", 32'd2, 32'd14);

        // second start on busy cycle 3 is ignored; operands wiggle during RUN
        step();
        issue(3'd0, 32'd1000, 32'hFFFF_FFFF, 1'b0);
        step();
        step();
        start = 1'b1; mdu_op = 3'd2; a = 32'd55; b = 32'd3;
        step();
        start = 1'b0; mdu_op = 3'd7; a = 32'h1234_5678; b = 32'd9;
        wait_idle(n);
        check("ignored_start_busy_total", n + 3, 32'd5);
        read_hilo("mult_neg1000", 32'hFFFF_FFFF, 32'hFFFF_FC18);

        step();
        issue(3'd4, 32'hDEAD_BEEF, 32'd0, 1'b1);
        mdu_op = 3'd6; #1;
        check("mfhi_data", rd_data, 32'hDEAD_BEEF);
        check("mthi_busy", {31'd0, busy}, 32'd0);
        step();

        // reset on busy cycle 7 of a DIV
        issue(3'd2, 32'd50, 32'd5, 1'b1);
        for (int i = 0; i < 6; i++) step();
        check("pre_reset_busy", {31'd0, busy}, 32'd1);
        reset = 1'b0; #1;
        check("abort_busy", {31'd0, busy}, 32'd0);
        check("abort_lo", rd_data, 32'd0);
        mdu_op = 3'd6; #1;
        check("abort_hi", rd_data, 32'd0);
        mdu_op = 3'd7;
        id_is_md = 1'b0;
        step();
        reset = 1'b1;
        issue(3'd0, 32'd1, 32'd1, 1'b0);
        wait_idle(n);
        check("post_reset_busy_cycles", n, 32'd5);
        read_hilo("post_reset_mult", 32'd0, 32'd1);

        step();
        step();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

    initial begin
        #50000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

endmodule
